// File: rtl/l1_mw_dp_mem_if.sv
// Bus bundle for l1_mw_dp_mem: read port, write port, flush request and ready status.
// The master side (L1 pipeline) drives requests; the slave side (array) returns data/status.
interface l1_mw_dp_mem_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int WAYS  = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic                    FLUSH;
  logic                    REN;
  logic [AW-1:0]           RADDR;
  logic                    RVALID;
  logic [WAYS*WIDTH-1:0]   RDATA;
  logic                    WEN;
  logic [WAYS-1:0]         WWAY;
  logic [AW-1:0]           WADDR;
  logic [NB-1:0]           WBE;
  logic [WIDTH-1:0]        WDATA;
  logic                    ready;

  modport master (
    output FLUSH, REN, RADDR, WEN, WWAY, WADDR, WBE, WDATA,
    input  RVALID, RDATA, ready
  );

  modport slave (
    input  FLUSH, REN, RADDR, WEN, WWAY, WADDR, WBE, WDATA,
    output RVALID, RDATA, ready
  );
endinterface

// File: rtl/l1_mw_dp_mem.sv
// Multi-way, byte-enabled 1R+1W L1 array built from 8-bit sram_dp lanes, with a clear sequencer.
// Optional same-address read/write forwarding is enabled by defining L1_MW_DP_MEM_BYPASS_EN.
module sram_dp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_comb rdata_d = mem[raddr];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

module l1_mw_dp_mem #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 1024,
  parameter int               WAYS     = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic           CLK,
  input logic           RST_N,
  l1_mw_dp_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  clearing;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [AW-1:0]         sram_waddr;
  logic [WIDTH-1:0]      sram_wdata;
  logic [WAYS*NB-1:0]    lane_we;
  logic [WAYS*WIDTH-1:0] sram_rdata;
  logic [WAYS*WIDTH-1:0] rd_lanes;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // A flush while clearing restarts the sweep so the last flush gets a full pass.
        if (bus.FLUSH) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_READY: begin
        if (bus.FLUSH) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign clearing   = (state_q == ST_CLEAR);
  assign rd_acc     = bus.REN & ~clearing;
  assign wr_acc     = bus.WEN & ~clearing;
  assign rvalid_d   = rd_acc;
  assign sram_waddr = clearing ? cnt_q : bus.WADDR;
  assign sram_wdata = clearing ? INIT_VAL : bus.WDATA;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef L1_MW_DP_MEM_BYPASS_EN
  logic [WAYS*NB-1:0] fwd_mask_q, fwd_mask_d;
  logic [WIDTH-1:0]   fwd_data_q, fwd_data_d;
  logic               same_addr;

  // lane_we is all-ones only while clearing, when rd_acc is already low.
  assign same_addr  = rd_acc & wr_acc & (bus.RADDR == bus.WADDR);
  assign fwd_mask_d = same_addr ? lane_we : '0;
  assign fwd_data_d = bus.WDATA;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`endif

  genvar gi, gb;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      for (gb = 0; gb < NB; gb++) begin : g_lane
        assign lane_we[gi*NB+gb] = clearing | (wr_acc & bus.WWAY[gi] & bus.WBE[gb]);

        sram_dp #(
          .DEPTH (DEPTH),
          .AW    (AW)
        ) u_lane (
          .CLK   (CLK),
          .we    (lane_we[gi*NB+gb]),
          .waddr (sram_waddr),
          .wdata (sram_wdata[gb*8 +: 8]),
          .re    (rd_acc),
          .raddr (bus.RADDR),
          .rdata (sram_rdata[gi*WIDTH+gb*8 +: 8])
        );

`ifdef L1_MW_DP_MEM_BYPASS_EN
        assign rd_lanes[gi*WIDTH+gb*8 +: 8] = fwd_mask_q[gi*NB+gb] ? fwd_data_q[gb*8 +: 8]
                                                                   : sram_rdata[gi*WIDTH+gb*8 +: 8];
`else
        assign rd_lanes[gi*WIDTH+gb*8 +: 8] = sram_rdata[gi*WIDTH+gb*8 +: 8];
`endif
      end
    end
  endgenerate

  assign bus.RVALID = rvalid_q;
  assign bus.RDATA  = rvalid_q ? rd_lanes : '0;
  assign bus.ready  = (state_q == ST_READY);
endmodule

// File: tb/tb_l1_mw_dp_mem.sv
// Directed bench for l1_mw_dp_mem (DEPTH=12, 4 ways x 32 bits, INIT_VAL=A5A5_A5A5).
// Collision forwarding is checked exactly when L1_MW_DP_MEM_BYPASS_EN is defined, masked otherwise.
module tb_l1_mw_dp_mem;
  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int WAYS  = 4;
  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam logic [31:0] INIT = 32'hA5A5_A5A5;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  l1_mw_dp_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAYS(WAYS)) bus ();

  l1_mw_dp_mem #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .WAYS     (WAYS),
    .INIT_VAL (INIT)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] model [WAYS][DEPTH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.FLUSH = 1'b0;
    bus.REN   = 1'b0;
    bus.RADDR = '0;
    bus.WEN   = 1'b0;
    bus.WWAY  = '0;
    bus.WADDR = '0;
    bus.WBE   = '0;
    bus.WDATA = '0;
  endtask

  function automatic logic [127:0] row(input int a);
    return {model[3][a], model[2][a], model[1][a], model[0][a]};
  endfunction

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int a = 0; a < DEPTH; a++)
        model[w][a] = INIT;
  endtask

  task automatic model_write(input logic [3:0] way, input int a, input logic [3:0] be,
                             input logic [31:0] data);
    for (int w = 0; w < WAYS; w++)
      for (int b = 0; b < NB; b++)
        if (way[w] && be[b]) model[w][a][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic do_write(input logic [3:0] way, input int a, input logic [3:0] be,
                          input logic [31:0] data);
    bus.WEN   = 1'b1;
    bus.WWAY  = way;
    bus.WADDR = a[AW-1:0];
    bus.WBE   = be;
    bus.WDATA = data;
    step();
    bus.WEN = 1'b0;
    model_write(way, a, be, data);
  endtask

  task automatic read_chk(input string tag, input int a);
    bus.REN   = 1'b1;
    bus.RADDR = a[AW-1:0];
    step();
    bus.REN = 1'b0;
    chk($sformatf("%s_rv", tag), {127'd0, bus.RVALID}, 128'd1);
    chk(tag, bus.RDATA, row(a));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  int          n;
  int          rv_seen;
  int          low;
  logic        exp_rv;
  logic [127:0] exp_d, exp_m;
  logic        ren, wen;
  int          ra, wa;
  logic [3:0]  way, be;
  logic [31:0] wd;

  initial begin
    idle();
    RST_N = 1'b0;
    step();
    step();
    chk("rst_ready",  {127'd0, bus.ready},  128'd0);
    chk("rst_rvalid", {127'd0, bus.RVALID}, 128'd0);
    chk("rst_rdata",  bus.RDATA,            128'd0);

    // Requests held high across the whole initial clear must be ignored.
    bus.REN   = 1'b1;
    bus.RADDR = 4'd5;
    bus.WEN   = 1'b1;
    bus.WWAY  = 4'hF;
    bus.WADDR = 4'd5;
    bus.WBE   = 4'hF;
    bus.WDATA = 32'hDEAD_DEAD;
    RST_N     = 1'b1;
    n = 0;
    rv_seen = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
      if (bus.RVALID === 1'b1) rv_seen++;
    end
    idle();
    chk("init_cycles",    n,       12);
    chk("blocked_rvalid", rv_seen, 0);

    model_clear();
    for (int a = 0; a < DEPTH; a++) read_chk($sformatf("init_a%0d", a), a);
    step();
    chk("idle_rvalid", {127'd0, bus.RVALID}, 128'd0);
    chk("idle_rdata",  bus.RDATA,            128'd0);

    do_write(4'b0100, 5, 4'b0011, 32'h1122_3344);
    bus.REN   = 1'b1;
    bus.RADDR = 4'd5;
    step();
    bus.REN = 1'b0;
    chk("be_way2",   bus.RDATA[95:64], 32'hA5A5_3344);
    chk("be_others", {bus.RDATA[127:96], bus.RDATA[63:0]}, {INIT, INIT, INIT});

    // Random back-to-back traffic; expectations for cycle i are checked at cycle i+1.
    step();
    exp_rv = 1'b0;
    exp_d  = '0;
    exp_m  = '1;
    for (int i = 0; i < 100; i++) begin
      chk("tp_rvalid", {127'd0, bus.RVALID}, {127'd0, exp_rv});
      chk("tp_rdata",  bus.RDATA & exp_m,    exp_d & exp_m);
      ren = 1'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      ra  = (i % 3 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 3));
      wa  = int'($urandom_range(0, 3));
      way = 4'($urandom_range(0, 15));
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      bus.REN   = ren;
      bus.RADDR = ra[AW-1:0];
      bus.WEN   = wen;
      bus.WWAY  = way;
      bus.WADDR = wa[AW-1:0];
      bus.WBE   = be;
      bus.WDATA = wd;
      exp_rv = ren;
      exp_d  = ren ? row(ra) : 128'd0;
      exp_m  = '1;
      if (ren && wen && ra == wa) begin
        for (int w = 0; w < WAYS; w++)
          for (int b = 0; b < NB; b++)
            if (way[w] && be[b]) begin
`ifdef L1_MW_DP_MEM_BYPASS_EN
              exp_d[w*32 + b*8 +: 8] = wd[b*8 +: 8];
`else
              exp_m[w*32 + b*8 +: 8] = 8'h00;
`endif
            end
      end
      if (wen) model_write(way, wa, be, wd);
      step();
    end
    chk("tp_rvalid_last", {127'd0, bus.RVALID}, {127'd0, exp_rv});
    chk("tp_rdata_last",  bus.RDATA & exp_m,    exp_d & exp_m);
    idle();
    step();

    // Flush, then re-flush on the third clear cycle: ready low DEPTH+3 samples.
    do_write(4'hF, 3, 4'hF, 32'h1234_5678);
    read_chk("pre_flush", 3);
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    chk("flush_drop", {127'd0, bus.ready}, 128'd0);
    low = 1;
    step();
    if (bus.ready !== 1'b1) low++;
    step();
    if (bus.ready !== 1'b1) low++;
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    if (bus.ready !== 1'b1) low++;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
      if (bus.ready !== 1'b1) low++;
    end
    chk("flush_low", low, DEPTH + 3);
    model_clear();
    for (int a = 0; a < DEPTH; a++) read_chk($sformatf("flush_a%0d", a), a);

    // Same-address read and write in one cycle.
    bus.REN   = 1'b1;
    bus.RADDR = 4'd7;
    bus.WEN   = 1'b1;
    bus.WWAY  = 4'b0001;
    bus.WADDR = 4'd7;
    bus.WBE   = 4'hF;
    bus.WDATA = 32'hDEAD_BEEF;
    step();
    idle();
    model_write(4'b0001, 7, 4'hF, 32'hDEAD_BEEF);
    chk("coll_rvalid", {127'd0, bus.RVALID}, 128'd1);
    chk("coll_other",  bus.RDATA[127:32], {INIT, INIT, INIT});
`ifdef L1_MW_DP_MEM_BYPASS_EN
    chk("coll_way0",   bus.RDATA[31:0],  32'hDEAD_BEEF);
`endif
    read_chk("coll_after", 7);

    // WWAY=0 and WBE=0 are no-ops.
    do_write(4'h0, 4, 4'hF, 32'hFFFF_FFFF);
    do_write(4'hF, 4, 4'h0, 32'hFFFF_FFFF);
    read_chk("noop_a4", 4);
    chk("noop_const", bus.RDATA, {INIT, INIT, INIT, INIT});

    // Asynchronous reset while a read result is being presented.
    bus.REN   = 1'b1;
    bus.RADDR = 4'd2;
    step();
    idle();
    chk("pre_arst_rv", {127'd0, bus.RVALID}, 128'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_rvalid", {127'd0, bus.RVALID}, 128'd0);
    chk("arst_rdata",  bus.RDATA,            128'd0);
    chk("arst_ready",  {127'd0, bus.ready},  128'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_ready(n);
    chk("arst_reclear", n, 12);
    model_clear();
    read_chk("arst_a7", 7);
    read_chk("arst_a3", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
